// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin shared-adder arbiter:
// default widths and the result-slot FSM encoding.
package adder_arb_pkg;

  localparam int DEF_N    = 32;
  localparam int DEF_NREQ = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the requesters and the shared-adder arbiter.
interface adder_arbiter_if #(
  parameter int N    = adder_arb_pkg::DEF_N,
  parameter int NREQ = adder_arb_pkg::DEF_NREQ
) ();

  localparam int IDW = $clog2(NREQ);

  // Handshakes: a request lane i transfers in a cycle where req_valid[i] and
  // req_ready[i] are both 1; the result transfers where resp_valid and
  // resp_ready are both 1. req_ready is a same-cycle one-hot grant.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_sum;
  logic              resp_carry;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

endinterface

// File: rtl/adder_core.sv
// Single N-bit adder with operand isolation: inputs are held at zero when
// en is low so the carry chain does not toggle on idle cycles.
module adder_core #(
  parameter int N = adder_arb_pkg::DEF_N
) (
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  logic [N-1:0] a_iso;
  logic [N-1:0] b_iso;

  always_comb begin
    a_iso = en ? a : '0;
    b_iso = en ? b : '0;
    {carry, sum} = {1'b0, a_iso} + {1'b0, b_iso};
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a single
// registered result slot (EMPTY/FULL) that can be refilled back to back.
module adder_arbiter import adder_arb_pkg::*; #(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder_arbiter_if.slave           bus,
  output state_e                   dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_ptr,
  output logic [N-1:0]             dbg_add_a,
  output logic [N-1:0]             dbg_add_b
);

  localparam int IDW = $clog2(NREQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;

  logic            slot_free;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic [IDW:0]    cand;
  logic [N-1:0]    op_a, op_b;
  logic [N-1:0]    add_sum;
  logic            add_carry;

  // Grant search walks ptr, ptr+1, ... modulo NREQ; the first valid wins.
  always_comb begin
    slot_free = (state_q == EMPTY) || bus.resp_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rst_n && slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
        if (!grant_vld && bus.req_valid[cand[IDW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    op_a     = '0;
    op_b     = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        op_a = bus.req_a[i*N +: N];
        op_b = bus.req_b[i*N +: N];
      end
    end
  end

  adder_core #(.N(N)) u_core (
    .en    (grant_vld),
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (grant_vld) begin
      state_d = FULL;
      sum_d   = add_sum;
      carry_d = add_carry;
      id_d    = grant_idx;
      ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end else if (state_q == FULL && bus.resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.req_ready  = grant_oh;
  assign bus.resp_valid = (state_q == FULL);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_carry = carry_q;

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_add_a = op_a;
  assign dbg_add_b = op_b;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus a randomized
// run scored against a round-robin reference model and an expected queue.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;

  adder_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  state_e         dbg_state;
  logic [IDW-1:0] dbg_ptr;
  logic [N-1:0]   dbg_add_a;
  logic [N-1:0]   dbg_add_b;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr),
    .dbg_add_a (dbg_add_a),
    .dbg_add_b (dbg_add_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int m_ptr  = 0;
  bit m_full = 1'b0;
  logic [IDW+N:0] exp_q[$];

  function automatic int calc_grant();
    int idx;
    if (!rst_n) return -1;
    if (m_full && !bus.resp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_oh(int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] opa(int i);
    return bus.req_a[i*N +: N];
  endfunction

  function automatic logic [N-1:0] opb(int i);
    return bus.req_b[i*N +: N];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = $urandom();
      bus.req_b[i*N +: N] = $urandom();
    end
  endtask

  // One clock: model commits with the inputs that were stable before the edge.
  task automatic step();
    int g;
    g = calc_grant();
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      m_full = 1'b1;
      m_ptr  = (g + 1) % NREQ;
    end else if (m_full && bus.resp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    randomize_ops();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b0 || dbg_ptr !== 2'd0 || dbg_state !== EMPTY) begin
        n_fail++;
        $display("FAIL reset_state: resp_valid=%b ptr=%0d exp 0/0", bus.resp_valid, dbg_ptr);
      end
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      randomize_ops();
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000 || dbg_add_a !== '0 || dbg_add_b !== '0) begin
        n_fail++;
        $display("FAIL idle_iso: ready=%b a=%h b=%h exp 0", bus.req_ready, dbg_add_a, dbg_add_b);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_resp_valid: got %b exp 0", bus.resp_valid);
      end
    end
  endtask

  task automatic test_all_valid();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [N:0] full_sum;
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      randomize_ops();
      #1;
      n_cmp++;
      if (bus.req_ready !== exp_oh(seq[i])) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", i, bus.req_ready, exp_oh(seq[i]));
      end
      full_sum = {1'b0, opa(seq[i])} + {1'b0, opb(seq[i])};
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== IDW'(seq[i]) ||
          {bus.resp_carry, bus.resp_sum} !== full_sum) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: v=%b id=%0d c=%b s=%h exp id=%0d c=%b s=%h", i,
                 bus.resp_valid, bus.resp_id, bus.resp_carry, bus.resp_sum,
                 seq[i], full_sum[N], full_sum[N-1:0]);
      end
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_single();
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b0;
    randomize_ops();
    bus.req_a[2*N +: N] = 32'hFFFF_FFFF;
    bus.req_b[2*N +: N] = 32'h0000_0001;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100 || dbg_add_a !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL single_grant: got %b a=%h exp 0100 ffffffff", bus.req_ready, dbg_add_a);
    end
    step();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_sum !== 32'h0 ||
        bus.resp_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp: v=%b id=%0d s=%h c=%b exp 1 2 0 1",
               bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry);
    end
    bus.resp_ready = 1'b1;
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got %b exp 0", bus.resp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N:0] held;
    logic [N:0] nxt;
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b0;
    randomize_ops();
    held = {1'b0, opa(0)} + {1'b0, opb(0)};
    step();
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      randomize_ops();
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b exp 0000", c, bus.req_ready);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 ||
          {bus.resp_carry, bus.resp_sum} !== held) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b id=%0d cs=%h exp 1 0 %h", c,
                 bus.resp_valid, bus.resp_id, {bus.resp_carry, bus.resp_sum}, held);
      end
    end
    bus.resp_ready = 1'b1;
    randomize_ops();
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release: got %b exp 0010", bus.req_ready);
    end
    nxt = {1'b0, opa(1)} + {1'b0, opb(1)};
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 ||
        {bus.resp_carry, bus.resp_sum} !== nxt) begin
      n_fail++;
      $display("FAIL bp_b2b: v=%b id=%0d cs=%h exp 1 1 %h",
               bus.resp_valid, bus.resp_id, {bus.resp_carry, bus.resp_sum}, nxt);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    randomize_ops();
    step();
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    #1;
    n_cmp++;
    if (dbg_ptr !== 2'd3 || bus.resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: ptr=%0d v=%b exp 3 1", dbg_ptr, bus.resp_valid);
    end
    rst_n = 1'b0;
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst_ready: got %b exp 0000", bus.req_ready);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || dbg_ptr !== 2'd0 || bus.resp_sum !== '0 ||
        bus.resp_id !== '0 || bus.resp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_clear: v=%b ptr=%0d s=%h id=%0d c=%b exp all 0",
               bus.resp_valid, dbg_ptr, bus.resp_sum, bus.resp_id, bus.resp_carry);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_grant: got %b exp 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_random();
    int g;
    logic [IDW+N:0] exp_v;
    logic [N:0] s;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid  = NREQ'($urandom_range(0, 15));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      randomize_ops();
      #1;
      g = calc_grant();
      n_cmp++;
      if (bus.req_ready !== exp_oh(g) || bus.resp_valid !== m_full) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: ready=%b v=%b exp %b %b", c, bus.req_ready,
                 bus.resp_valid, exp_oh(g), m_full);
      end
      n_cmp++;
      if (dbg_add_a !== ((g >= 0) ? opa(g) : '0) || dbg_add_b !== ((g >= 0) ? opb(g) : '0)) begin
        n_fail++; $display("FAIL rnd_iso[%0d]: a=%h b=%h grant=%0d", c, dbg_add_a, dbg_add_b, g);
      end
      if (m_full && bus.resp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_deliver[%0d]: got delivery exp empty queue", c);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.resp_id, bus.resp_carry, bus.resp_sum} !== exp_v) begin
            n_fail++;
            $display("FAIL rnd_deliver[%0d]: got %h exp %h", c,
                     {bus.resp_id, bus.resp_carry, bus.resp_sum}, exp_v);
          end
        end
      end
      if (g >= 0) begin
        s = {1'b0, opa(g)} + {1'b0, opb(g)};
        exp_q.push_back({IDW'(g), s});
      end
      step();
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    #1;
    if (m_full) begin
      n_cmp++;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      if ({bus.resp_id, bus.resp_carry, bus.resp_sum} !== exp_v) begin
        n_fail++;
        $display("FAIL rnd_last: got %h exp %h", {bus.resp_id, bus.resp_carry, bus.resp_sum}, exp_v);
      end
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_end: v=%b left=%0d exp 0 0", bus.resp_valid, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_valid();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
